exe_mem_stage: RTL
==================

Name: exe_mem_stage

Overview:
- Sits directly downstream of the execute-stage ALU.
- Captures the ALU result, flags and memory/write-back controls into the EXE→MEM boundary through a 2-entry skid buffer with valid/ready handshakes.
- Owns the architectural NZCV status register, updated by S-bit instructions; its C bit feeds back as the ALU carry-in.
- Supports pipeline flush (branch taken) and a downstream stall without dropping instructions.

Parameters:
- DW, 32, data width of ALU result and store value
- RW, 4, destination register index width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- valid_in  input  1  upstream (EXE) entry valid
- ready_out  output  1  block can accept an entry this cycle
- alu_res  input  DW  ALU result
- nzcv_in  input  4  ALU flags {N,Z,C,V}
- s_bit  input  1  instruction updates status
- wb_en_in  input  1  write-back enable
- mem_r_en_in  input  1  load
- mem_w_en_in  input  1  store
- dest_in  input  RW  destination register
- val_rm_in  input  DW  store data
- flush  input  1  kill all held entries and the incoming entry
- valid_out  output  1  head entry valid toward MEM
- ready_in  input  1  MEM accepts head entry
- alu_res_out  output  DW  head ALU result
- wb_en_out, mem_r_en_out, mem_w_en_out  output  1 each  head controls
- dest_out  output  RW  head destination
- val_rm_out  output  DW  head store data
- status_out  output  4  architectural NZCV
- c_out  output  1  carry to ALU c_in (= status_out[1] unless bypass enabled)

Behaviour:
- Reset (rst_n=0 at clk edge): both entries invalid, valid_out=0, ready_out=1, status_out=4'b0000, all payload outputs 0. Reset mid-transfer discards everything; reset dominates flush.
- Storage: head register (drives outputs) plus skid register. States: EMPTY (no valid entries), ONE (head valid), FULL (head+skid valid).
- ready_out is registered: 1 in EMPTY/ONE, 0 in FULL. No combinational path from ready_in to ready_out.
- Accept = valid_in & ready_out & ~flush. Pop = valid_out & ready_in.
- EMPTY: accept → load head, go ONE.
- ONE: pop only → EMPTY; accept only → load skid, go FULL; accept+pop → load head with new entry, stay ONE.
- FULL: pop → skid moves to head, go ONE; no pop → hold.
- Ordering strictly FIFO; no entry duplicated or lost.
- Payload values with valid=0 are don't-care but are held (no toggling) while invalid.
- flush=1: next state EMPTY, ready_out=1 next cycle, incoming entry dropped. A pop coinciding with flush still counts as taken by MEM this cycle.
- Status: on accept with s_bit=1, status_out <= nzcv_in at the edge. Updates occur at acceptance, not at pop. Flushed or unaccepted entries never change status. An s_bit=0 accept leaves status unchanged.
- Latency: input to valid_out is 1 cycle when EMPTY. Throughput is 1/cycle with ready_in held at 1.

Optional Feature:
- Macro: EXE_STATUS_BYPASS_EN
- Defined: c_out = (valid_in & ready_out & ~flush & s_bit) ? nzcv_in[1] : status_out[1]. Combinational forward of the carry being written this cycle, for back-to-back ADC/SBC chains within the same stage.
- Undefined: c_out = status_out[1] (registered only). Upstream logic must handle the 1-cycle status latency.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with valid_in=1 → valid_out=0, ready_out=1, status_out=0000 on the first cycle after release.
- Streaming: ready_in=1, send alu_res 1,2,3 on consecutive cycles → alu_res_out 1,2,3 on cycles 1,2,3, valid_out high throughout.
- Backpressure: ready_in=0, send A=0x10 then B=0x20 → ready_out=0 after the second accept, C held off. Raise ready_in → outputs 0x10 then 0x20, ready_out returns to 1.
- Status: accept s_bit=1 nzcv=0110, then s_bit=0 nzcv=1001 → status_out=0110 after both. A flushed s_bit=1 nzcv=1111 leaves status at 0110.
- Flush in FULL with valid_in=1 → next cycle valid_out=0, ready_out=1, dropped entries never appear.
- Bypass: with EXE_STATUS_BYPASS_EN defined, status C=0, accept s_bit=1 nzcv=0010 → c_out=1 in the same cycle. With the macro undefined → c_out=0 that cycle and 1 the next.

Source files
------------

// File: rtl/exe_mem_stage.sv
// exe_mem_stage: EXE->MEM boundary, 2-entry skid buffer plus NZCV status.
// Optional macro EXE_STATUS_BYPASS_EN forwards the carry being written.
module exe_mem_stage #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    output logic          ready_out,
    input  logic [DW-1:0] alu_res,
    input  logic [3:0]    nzcv_in,
    input  logic          s_bit,
    input  logic          wb_en_in,
    input  logic          mem_r_en_in,
    input  logic          mem_w_en_in,
    input  logic [RW-1:0] dest_in,
    input  logic [DW-1:0] val_rm_in,
    input  logic          flush,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [DW-1:0] alu_res_out,
    output logic          wb_en_out,
    output logic          mem_r_en_out,
    output logic          mem_w_en_out,
    output logic [RW-1:0] dest_out,
    output logic [DW-1:0] val_rm_out,
    output logic [3:0]    status_out,
    output logic          c_out
);

    typedef struct packed {
        logic [DW-1:0] alu_res;
        logic          wb_en;
        logic          mem_r_en;
        logic          mem_w_en;
        logic [RW-1:0] dest;
        logic [DW-1:0] val_rm;
    } ent_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    ent_t       head;
    ent_t       skid;
    ent_t       head_nxt;
    ent_t       skid_nxt;
    ent_t       in_ent;
    logic       ready_q;
    logic       accept;
    logic       pop;
    logic [3:0] status_q;

    assign in_ent = {alu_res, wb_en_in, mem_r_en_in, mem_w_en_in,
                     dest_in, val_rm_in};

    assign valid_out = (state != EMPTY);
    assign ready_out = ready_q;
    assign accept    = valid_in & ready_q & ~flush;
    assign pop       = valid_out & ready_in;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    head_nxt  = in_ent;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_nxt = in_ent;
                end else if (accept) begin
                    skid_nxt  = in_ent;
                    state_nxt = FULL;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_nxt  = skid;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // flushed entries leave payload untouched so it stays quiet
        if (flush) begin
            state_nxt = EMPTY;
            head_nxt  = head;
            skid_nxt  = skid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            head     <= '0;
            skid     <= '0;
            ready_q  <= 1'b1;
            status_q <= 4'b0000;
        end else begin
            state   <= state_nxt;
            head    <= head_nxt;
            skid    <= skid_nxt;
            ready_q <= (state_nxt != FULL);
            if (accept && s_bit) begin
                status_q <= nzcv_in;
            end
        end
    end

    assign alu_res_out  = head.alu_res;
    assign wb_en_out    = head.wb_en;
    assign mem_r_en_out = head.mem_r_en;
    assign mem_w_en_out = head.mem_w_en;
    assign dest_out     = head.dest;
    assign val_rm_out   = head.val_rm;
    assign status_out   = status_q;

`ifdef EXE_STATUS_BYPASS_EN
    assign c_out = (accept & s_bit) ? nzcv_in[1] : status_q[1];
`else
    assign c_out = status_q[1];
`endif

endmodule
